// File: rtl/rv_pkg.sv
// Shared fetch-path types: packet layout between fetch and decode, fetch FSM states.
package rv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            misalign;
   } fetch_pkt_t;

   typedef enum logic {
      FETCH_RUN,
      FETCH_HALT
   } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetch packets; flush beats push/pop, head reads as zero when empty.
module fetch_queue
   import rv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  fetch_pkt_t                   push_pkt,
   output fetch_pkt_t                   head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_pkt_t        mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count_q;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries data only; a full-queue push overwrites the slot being popped this cycle.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_pkt;
   end

   assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
   assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// PC, RUN/HALT fetch FSM and ROM addressing feeding a fetch_queue toward decode.
// Optional misaligned-fetch fault reporting is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
   import rv_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DEPTH      = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_pc_plus4,
   output logic [31:0]           out_instr,
   output logic                  out_misalign
);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   pc_q;
   fetch_state_e  state_q;
   fetch_state_e  state_d;
   logic          push;
   logic          pop;
   fetch_pkt_t    push_pkt;
   fetch_pkt_t    head;
   logic [CW-1:0] count;

   function automatic logic [31:0] load_pc(input logic [31:0] target);
`ifdef FETCH_MISALIGN_CHECK_EN
      return target;
`else
      return target & ~32'd3;
`endif
   endfunction

   assign pop       = out_valid && out_ready;
   assign imem_addr = pc_q[ADDR_WIDTH+1:2];

   always_comb begin
      state_d  = state_q;
      push     = 1'b0;
      push_pkt = '{pc: pc_q, instr: imem_data, misalign: 1'b0};
      if (redirect_valid) begin
         state_d = FETCH_RUN;
      end else if (state_q == FETCH_RUN && (count < CW'(DEPTH) || pop)) begin
         push = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
         // A misaligned PC emits one fault packet, then fetch parks until redirected.
         if (pc_q[1:0] != 2'b00) begin
            push_pkt.instr    = NOP_INSTR;
            push_pkt.misalign = 1'b1;
            state_d           = FETCH_HALT;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= load_pc(RESET_PC);
         state_q <= FETCH_RUN;
      end else begin
         state_q <= state_d;
         if (redirect_valid) pc_q <= load_pc(redirect_pc);
         else if (push)      pc_q <= pc_q + 32'd4;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (redirect_valid),
      .push_pkt (push_pkt),
      .head     (head),
      .count    (count)
   );

   assign out_valid    = (count != '0);
   assign out_pc       = head.pc;
   assign out_pc_plus4 = head.pc + 32'd4;
   assign out_instr    = head.instr;
   assign out_misalign = head.misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a ROM model where ROM[i] = i.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [31:0] out_instr;
   logic        out_misalign;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   assign imem_data = {22'd0, imem_addr};

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .out_instr      (out_instr),
      .out_misalign   (out_misalign)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      check_eq({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, " pc"}, out_pc, pc);
      check_eq({tag, " instr"}, out_instr, instr);
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      step();
      step();
      check_eq("reset valid", {31'd0, out_valid}, 32'd0);
      check_eq("reset pc", out_pc, 32'd0);
      check_eq("reset instr", out_instr, 32'd0);
      check_eq("reset misalign", {31'd0, out_misalign}, 32'd0);
      check_eq("reset addr", {22'd0, imem_addr}, 32'd0);

      // streaming, one instruction per cycle
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_head($sformatf("stream%0d", i), 32'(4 * i), 32'(i));
      end
      check_eq("stream plus4", out_pc_plus4, 32'd20);

      // backpressure: queue fills to two entries, pc stalls
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_head("stall head", 32'd16, 32'd4);
      check_eq("stall addr", {22'd0, imem_addr}, 32'd6);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_head($sformatf("drain%0d", i), 32'(20 + 4 * i), 32'(5 + i));
      end

      // redirect with a full queue and a concurrent pop
      redirect(32'h40);
      check_eq("redir flush valid", {31'd0, out_valid}, 32'd0);
      check_eq("redir addr", {22'd0, imem_addr}, 32'h10);
      step();
      check_head("redir target", 32'h40, 32'h10);
      step();
      check_head("redir next", 32'h44, 32'h11);

      // ROM address wrap and 32-bit pc wrap
      redirect(32'hFFC);
      check_eq("wrap addr hi", {22'd0, imem_addr}, 32'h3FF);
      step();
      check_head("wrap ffc", 32'hFFC, 32'h3FF);
      check_eq("wrap addr lo", {22'd0, imem_addr}, 32'h0);
      check_eq("wrap plus4", out_pc_plus4, 32'h1000);
      step();
      check_head("wrap 1000", 32'h1000, 32'h0);
      redirect(32'hFFFF_FFFC);
      step();
      check_head("pcwrap top", 32'hFFFF_FFFC, 32'h3FF);
      check_eq("pcwrap plus4", out_pc_plus4, 32'h0);
      step();
      check_head("pcwrap zero", 32'h0, 32'h0);

      // misaligned redirect target
      redirect(32'h42);
      step();
`ifdef FETCH_MISALIGN_CHECK_EN
      check_head("misalign pkt", 32'h42, 32'h13);
      check_eq("misalign flag", {31'd0, out_misalign}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("halt valid%0d", i), {31'd0, out_valid}, 32'd0);
      end
`else
      check_head("align down", 32'h40, 32'h10);
      check_eq("align flag", {31'd0, out_misalign}, 32'd0);
      step();
      check_head("align next", 32'h44, 32'h11);
`endif
      redirect(32'h80);
      step();
      check_head("resume", 32'h80, 32'h20);
      check_eq("resume flag", {31'd0, out_misalign}, 32'd0);

      // reset beats a concurrent redirect with a full queue
      out_ready = 1'b0;
      step();
      step();
      rst_n          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      check_eq("rst redir valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst redir addr", {22'd0, imem_addr}, 32'd0);
      check_eq("rst redir pc", out_pc, 32'd0);
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step();
      check_head("post rst", 32'd0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
